// File: rtl/serial_loader_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel word loader.
package serial_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } loader_state_t;

  // Wide enough to count 0..WIDTH, which also covers the parity bit slot.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_nibble_loader_shift_collector.sv
// Shift register and bit counter; assembles data bits in the chosen order and
// flags the accept edge that completes a frame.
module shift_collector #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0,
  parameter int CW        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             accept,
  input  logic             ser_data,
  output logic [WIDTH-1:0] word,
  output logic             frame_done,
  output logic             parity_bit
);

  localparam int FRAME = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] WLIM = CW'(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             data_bit;

  always_comb begin
    if (MSB_FIRST != 0) shifted = {shreg[WIDTH-2:0], ser_data};
    else                shifted = {ser_data, shreg[WIDTH-1:1]};
  end

  assign data_bit   = (cnt < WLIM);
  assign frame_done = accept && (cnt == LAST);
  // With parity the last bit is the parity bit, so the word is already complete.
  assign word       = (PARITY_EN != 0) ? shreg : shifted;
  assign parity_bit = ser_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (accept) begin
      if (data_bit) shreg <= shifted;
      cnt <= frame_done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_nibble_loader.sv
// Serial bit stream to parallel word with valid/ready on both sides and an
// optional even-parity check per word.
module serial_nibble_loader
  import serial_loader_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ser_data,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             parity_err
);

  localparam int CW = cnt_width(WIDTH);

  loader_state_t    state_reg, state_next;
  logic             accept;
  logic [WIDTH-1:0] word;
  logic             frame_done;
  logic             parity_bit;

  assign ser_ready = (state_reg != FULL);
  assign accept    = ser_valid && ser_ready && !clr;

  shift_collector #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .PARITY_EN(PARITY_EN),
    .CW       (CW)
  ) u_collector (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .accept    (accept),
    .ser_data  (ser_data),
    .word      (word),
    .frame_done(frame_done),
    .parity_bit(parity_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    if (accept) state_next = frame_done ? FULL : SHIFT;
        SHIFT:   if (frame_done) state_next = FULL;
        FULL:    if (par_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // par_data deliberately survives clr so the downstream register input stays quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_data   <= '0;
      par_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else if (clr) begin
      par_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else if (frame_done) begin
      par_data   <= word;
      parity_err <= (PARITY_EN != 0) ? ((^word) ^ parity_bit) : 1'b0;
      par_valid  <= 1'b1;
    end else if (par_valid && par_ready) begin
      par_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_nibble_loader.sv
// Directed bench: MSB-first, LSB-first and parity-enabled loaders share one stimulus stream.
module tb_serial_nibble_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic ser_data = 1'b0;
  logic ser_valid = 1'b0;
  logic par_ready = 1'b0;

  logic       m_ready, m_valid, m_perr;
  logic [3:0] m_data;
  logic       l_ready, l_valid, l_perr;
  logic [3:0] l_data;
  logic       p_ready, p_valid, p_perr;
  logic [3:0] p_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_ready(m_ready), .par_data(m_data), .par_valid(m_valid), .par_ready(par_ready),
    .parity_err(m_perr));

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_ready(l_ready), .par_data(l_data), .par_valid(l_valid), .par_ready(par_ready),
    .parity_err(l_perr));

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(1)) u_par (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_ready(p_ready), .par_data(p_data), .par_valid(p_valid), .par_ready(par_ready),
    .parity_err(p_perr));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic d);
    ser_valid = v;
    ser_data  = d;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_valid", {7'd0, m_valid}, 8'd0);
    check("rst_data",  {4'd0, m_data},  8'd0);
    check("rst_perr",  {7'd0, p_perr},  8'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ser_ready", {7'd0, m_ready}, 8'd1);

    // 1: MSB first 1,0,1,0 with par_ready high
    par_ready = 1'b1;
    send(1, 1); send(1, 0); send(1, 1);
    check("t1_no_early", {7'd0, m_valid}, 8'd0);
    send(1, 0);
    check("t1_valid", {7'd0, m_valid}, 8'd1);
    check("t1_data",  {4'd0, m_data},  8'h0A);
    check("t1_busy",  {7'd0, m_ready}, 8'd0);
    send(0, 0);
    check("t1_drop",  {7'd0, m_valid}, 8'd0);
    check("t1_ready", {7'd0, m_ready}, 8'd1);

    // 2: LSB first 1,1,0,0 then stall downstream
    do_reset();
    par_ready = 1'b0;
    send(1, 1); send(1, 1); send(1, 0); send(1, 0);
    check("t2_data", {4'd0, l_data}, 8'h03);
    for (int i = 0; i < 5; i++) begin
      send(1, i[0]);
      check("t2_hold_data",  {4'd0, l_data},  8'h03);
      check("t2_hold_valid", {7'd0, l_valid}, 8'd1);
      check("t2_hold_ready", {7'd0, l_ready}, 8'd0);
    end
    par_ready = 1'b1;
    send(0, 0);
    check("t2_release", {7'd0, l_valid}, 8'd0);
    check("t2_idle_rdy", {7'd0, l_ready}, 8'd1);
    send(1, 1); send(1, 0); send(1, 0); send(1, 1);
    check("t2_next_word", {4'd0, l_data}, 8'h09);
    send(0, 0);

    // 3: gaps in the MSB-first stream: 1,_,_,1,_,0,1
    do_reset();
    send(1, 1); send(0, 0); send(0, 1); send(1, 1); send(0, 1); send(1, 0);
    check("t3_no_early", {7'd0, m_valid}, 8'd0);
    send(1, 1);
    check("t3_valid", {7'd0, m_valid}, 8'd1);
    check("t3_data",  {4'd0, m_data},  8'h0D);
    send(0, 0);

    // 4: parity frames (data 1011, good then bad parity)
    do_reset();
    send(1, 1); send(1, 0); send(1, 1); send(1, 1);
    check("t4_wait_parity", {7'd0, p_valid}, 8'd0);
    send(1, 1);
    check("t4a_valid", {7'd0, p_valid}, 8'd1);
    check("t4a_data",  {4'd0, p_data},  8'h0B);
    check("t4a_perr",  {7'd0, p_perr},  8'd0);
    send(0, 0);
    send(1, 1); send(1, 0); send(1, 1); send(1, 1); send(1, 0);
    check("t4b_data", {4'd0, p_data}, 8'h0B);
    check("t4b_perr", {7'd0, p_perr}, 8'd1);
    send(0, 0);

    // 5: clr drops partial word, then clr in FULL
    do_reset();
    send(1, 1); send(1, 1);
    clr = 1'b1;
    send(1, 1);
    clr = 1'b0;
    send(1, 0); send(1, 1); send(1, 0);
    check("t5_no_early", {7'd0, m_valid}, 8'd0);
    par_ready = 1'b0;
    send(1, 1);
    check("t5_data",  {4'd0, m_data},  8'h05);
    check("t5_valid", {7'd0, m_valid}, 8'd1);
    clr = 1'b1;
    send(0, 0);
    clr = 1'b0;
    check("t5_clr_valid", {7'd0, m_valid}, 8'd0);
    check("t5_clr_keep",  {4'd0, m_data},  8'h05);
    check("t5_clr_ready", {7'd0, m_ready}, 8'd1);

    // 6: asynchronous reset mid-SHIFT and mid-FULL
    send(1, 1); send(1, 0);
    ser_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_shift_data",  {4'd0, m_data},  8'h00);
    check("t6_shift_valid", {7'd0, m_valid}, 8'd0);
    rst_n = 1'b1;
    send(1, 1); send(1, 1); send(1, 1); send(1, 1); send(1, 1);
    check("t6_full_msb",  {7'd0, m_valid}, 8'd1);
    check("t6_full_perr", {7'd0, p_perr},  8'd1);
    ser_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {7'd0, m_valid}, 8'd0);
    check("t6_rst_data",  {4'd0, m_data},  8'h00);
    check("t6_rst_perr",  {7'd0, p_perr},  8'd0);
    check("t6_rst_pvalid", {7'd0, p_valid}, 8'd0);
    rst_n = 1'b1;
    par_ready = 1'b1;
    send(1, 1); send(1, 0); send(1, 0); send(1, 0);
    check("t6_recover", {4'd0, m_data}, 8'h08);
    check("t6_recover_valid", {7'd0, m_valid}, 8'd1);
    send(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
